// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common command bytes
// and the odd-parity helper used on the wire.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        WAIT_IDLE,
        ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines, plus a
// falling-edge strobe on the synchronized clock. Shared with the receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw_clk,
    input  logic raw_dat,
    output logic sync_clk,
    output logic sync_dat,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Lines idle high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], raw_clk};
            dat_ff   <= {dat_ff[0], raw_dat};
            clk_prev <= clk_ff[1];
        end
    end

    assign sync_clk = clk_ff[1];
    assign sync_dat = dat_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, eleven
// device-clocked bits, then ACK check. Drives the lines open-drain style.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    // Chosen so ERR is entered exactly TIMEOUT_CYC cycles after the RTS cycle.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 2);

    ps2_tx_state_t state;
    ps2_tx_state_t next_state;

    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          dat_low;
    logic          done_q;
    logic          ret_q;

    logic sync_clk;
    logic sync_dat;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .raw_clk  (PS2_CLK),
        .raw_dat  (PS2_DAT),
        .sync_clk (sync_clk),
        .sync_dat (sync_dat),
        .clk_fall (clk_fall)
    );

    // ret_q blocks a start in the first IDLE cycle after a transfer ends.
    always_comb begin
        next_state        = state;
        tx_busy           = (state != IDLE);
        tx_error          = 1'b0;
        ps2_clk_drive_low = 1'b0;
        ps2_dat_drive_low = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start && !ret_q) next_state = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_drive_low = 1'b1;
                if (cnt == INHIBIT_LAST) next_state = RTS;
            end
            RTS: begin
                ps2_dat_drive_low = 1'b1;
                next_state        = DATA;
            end
            DATA: begin
                ps2_dat_drive_low = dat_low;
                if (clk_fall) begin
                    if (bitcnt == 4'd10) next_state = sync_dat ? ERR : WAIT_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = ERR;
                end
            end
            WAIT_IDLE: begin
                if (sync_clk && sync_dat) next_state = IDLE;
                else if (cnt == TIMEOUT_LAST) next_state = ERR;
            end
            ERR: begin
                tx_error   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Data bits update on the cycle after a detected fall, while the clock is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            dat_low <= 1'b0;
            done_q  <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (state == WAIT_IDLE) && (next_state == IDLE);
            ret_q  <= (state != IDLE) && (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (next_state == INHIBIT) begin
                        shreg  <= tx_data;
                        parity <= odd_parity(tx_data);
                        cnt    <= '0;
                    end
                end
                INHIBIT: cnt <= cnt + CW'(1);
                RTS: begin
                    cnt     <= '0;
                    bitcnt  <= '0;
                    dat_low <= 1'b1;
                end
                DATA, WAIT_IDLE: begin
                    if (clk_fall) cnt <= '0;
                    else          cnt <= cnt + CW'(1);
                    if (state == DATA && clk_fall) begin
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            dat_low <= ~shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end else if (bitcnt == 4'd8) begin
                            dat_low <= ~parity;
                        end else begin
                            dat_low <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_done = done_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain 10 kHz device model
// that samples on rising edges and optionally ACKs on the 11th clock.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int total;
    int bad;
    int done_total;
    int err_total;
    int overlap_bad;
    int done_busy_bad;
    logic prev_busy;

    assign PS2_CLK = ~(ps2_clk_drive_low | dev_clk_low);
    assign PS2_DAT = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (100),
        .TIMEOUT_US  (2000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .tx_busy           (tx_busy),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .PS2_CLK           (PS2_CLK),
        .PS2_DAT           (PS2_DAT),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts done/error pulses and flags illegal combinations.
    initial begin
        done_total    = 0;
        err_total     = 0;
        overlap_bad   = 0;
        done_busy_bad = 0;
        prev_busy     = 1'b0;
    end

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_total <= done_total + 1;
            if (tx_busy !== 1'b0 || prev_busy !== 1'b1) done_busy_bad <= done_busy_bad + 1;
        end
        if (tx_error === 1'b1) err_total <= err_total + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) overlap_bad <= overlap_bad + 1;
        prev_busy <= tx_busy;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_rts(output int inh, output bit seen);
        int n;
        inh  = 0;
        n    = 0;
        while (!(PS2_CLK === 1'b1 && PS2_DAT === 1'b0) && n < 1000) begin
            if (ps2_clk_drive_low === 1'b1) inh++;
            @(negedge clk);
            n++;
        end
        seen = (PS2_CLK === 1'b1 && PS2_DAT === 1'b0);
    endtask

    task automatic device_receive(input bit ack, output logic [10:0] frame,
                                  output int inh, output bit seen);
        frame = '1;
        wait_rts(inh, seen);
        if (!seen) return;
        repeat (10) @(negedge clk);
        frame[0] = PS2_DAT;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            frame[i] = PS2_DAT;
            repeat (50) @(negedge clk);
        end
        if (ack) dev_dat_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", tx_busy); end
        total++;
        if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", tx_done); end
        total++;
        if (tx_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", tx_error); end
        total++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_lines: got clk=%b dat=%b want 0 0", ps2_clk_drive_low, ps2_dat_drive_low);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_set_leds();
        logic [10:0] frame;
        int inh, n, d0, e0;
        bit seen;
        d0 = done_total;
        e0 = err_total;
        start_tx(8'hED);
        device_receive(1'b1, frame, inh, seen);
        total++;
        if (inh != 100) begin bad++; $display("[TB] FAIL leds_inhibit: got %0d want 100", inh); end
        total++;
        if (frame !== 11'h7DA) begin bad++; $display("[TB] FAIL leds_frame: got %h want 7da", frame); end
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (tx_busy !== 1'b0 || tx_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL leds_done_busy: got done=%b busy=%b want 1 0", tx_done, tx_busy);
        end
        repeat (10) @(negedge clk);
        total++;
        if (done_total - d0 != 1 || err_total - e0 != 0) begin
            bad++;
            $display("[TB] FAIL leds_pulses: got done=%0d err=%0d want 1 0", done_total - d0, err_total - e0);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  bytes [2];
        logic [10:0] frames [2];
        logic [10:0] frame;
        int inh, n, d0;
        bit seen;
        bytes[0] = 8'h01; frames[0] = 11'h402;
        bytes[1] = 8'h00; frames[1] = 11'h600;
        for (int k = 0; k < 2; k++) begin
            d0 = done_total;
            start_tx(bytes[k]);
            device_receive(1'b1, frame, inh, seen);
            total++;
            if (frame !== frames[k]) begin
                bad++;
                $display("[TB] FAIL parity_frame_%h: got %h want %h", bytes[k], frame, frames[k]);
            end
            n = 0;
            while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            repeat (10) @(negedge clk);
            total++;
            if (done_total - d0 != 1) begin
                bad++;
                $display("[TB] FAIL parity_done_%h: got %0d want 1", bytes[k], done_total - d0);
            end
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] frame;
        int inh, d0, e0;
        bit seen;
        d0 = done_total;
        e0 = err_total;
        start_tx(8'hFF);
        device_receive(1'b0, frame, inh, seen);
        repeat (10) @(negedge clk);
        total++;
        if (err_total - e0 != 1 || done_total - d0 != 0) begin
            bad++;
            $display("[TB] FAIL noack_pulses: got err=%0d done=%0d want 1 0", err_total - e0, done_total - d0);
        end
        total++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0 || tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL noack_release: got clk=%b dat=%b busy=%b want 0 0 0",
                     ps2_clk_drive_low, ps2_dat_drive_low, tx_busy);
        end
    endtask

    task automatic test_timeout();
        int inh, n;
        bit seen;
        start_tx(8'hED);
        wait_rts(inh, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL timeout_rts: got none want rts"); end
        n = 0;
        while (tx_error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        total++;
        if (n != 2000) begin bad++; $display("[TB] FAIL timeout_cycles: got %0d want 2000", n); end
        total++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_release: got clk=%b dat=%b want 0 0", ps2_clk_drive_low, ps2_dat_drive_low);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [10:0] frame;
        int inh, n, d0;
        bit seen;
        d0 = done_total;
        start_tx(8'hED);
        fork
            device_receive(1'b1, frame, inh, seen);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        total++;
        if (frame !== 11'h7DA) begin bad++; $display("[TB] FAIL ignored_frame: got %h want 7da", frame); end
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++;
        if (done_total - d0 != 1 || tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignored_done: got done=%0d busy=%b want 1 0", done_total - d0, tx_busy);
        end
    endtask

    task automatic test_reset_mid_data();
        int inh, d0, e0;
        bit seen;
        start_tx(8'hFF);
        wait_rts(inh, seen);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (50) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        d0 = done_total;
        e0 = err_total;
        rst = 1'b0;
        #1;
        total++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_dat_drive_low !== 1'b0 || tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_release: got clk=%b dat=%b busy=%b want 0 0 0",
                     ps2_clk_drive_low, ps2_dat_drive_low, tx_busy);
        end
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (done_total != d0 || err_total != e0 || tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_pulses: got done=%0d err=%0d busy=%b want 0 0 0",
                     done_total - d0, err_total - e0, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] frame;
        int inh, n, d0;
        bit seen;
        d0 = done_total;
        start_tx(8'hED);
        device_receive(1'b1, frame, inh, seen);
        total++;
        if (frame !== 11'h7DA) begin bad++; $display("[TB] FAIL b2b_frame0: got %h want 7da", frame); end
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        start_tx(8'h07);
        device_receive(1'b1, frame, inh, seen);
        total++;
        if (inh != 100) begin bad++; $display("[TB] FAIL b2b_inhibit1: got %0d want 100", inh); end
        total++;
        if (frame !== 11'h40E) begin bad++; $display("[TB] FAIL b2b_frame1: got %h want 40e", frame); end
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++;
        if (done_total - d0 != 2) begin bad++; $display("[TB] FAIL b2b_done: got %0d want 2", done_total - d0); end
    endtask

    task automatic test_invariants();
        total++;
        if (overlap_bad != 0) begin bad++; $display("[TB] FAIL done_error_overlap: got %0d want 0", overlap_bad); end
        total++;
        if (done_busy_bad != 0) begin bad++; $display("[TB] FAIL done_busy_edge: got %0d want 0", done_busy_bad); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        $display("[TB] starting ps2_host_tx bench");
        test_reset();
        test_set_leds();
        test_parity();
        test_no_ack();
        test_timeout();
        test_start_ignored();
        test_reset_mid_data();
        test_back_to_back();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to a keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the host-initiated protocol: inhibit, request-to-send, device-clocked data, then device ACK.
- Complements the existing PS/2 scan-code receiver and shares the same PS2_CLK/PS2_DAT pins through open-drain pull-down controls.
- The top level asserts its receiver-suppress signal while tx_busy=1.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; used to derive cycle counts.
- INHIBIT_US, 120, time the clock is held low before request-to-send (min 100 us).
- TIMEOUT_US, 15000, maximum wait for each device clock falling edge before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tx_data  in  8  byte to send; latched when a start is accepted
- tx_start  in  1  one-cycle request; ignored while tx_busy=1
- tx_busy  out  1  high from the accept cycle until the return to IDLE
- tx_done  out  1  one-cycle pulse: byte sent and device ACK received
- tx_error  out  1  one-cycle pulse: timeout or missing ACK
- PS2_CLK  in  1  PS/2 clock line, raw/asynchronous
- PS2_DAT  in  1  PS/2 data line, raw/asynchronous
- ps2_clk_drive_low  out  1  1 = pull the clock line low; 0 = release it (top level tristates)
- ps2_dat_drive_low  out  1  1 = pull the data line low; 0 = release it

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; both lines released. A reset in any state releases the lines immediately with no error pulse.
- PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer. A falling edge (fall) is sync_clk: 1 to 0 between consecutive cycles.
- INHIBIT_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US. TIMEOUT_CYC is derived the same way. Counter width = $clog2(TIMEOUT_CYC+1).
- IDLE: tx_start=1 latches tx_data into shreg[7:0] and computes parity = ~^tx_data (odd parity). Next cycle: tx_busy=1, go to INHIBIT, cnt=0.
- INHIBIT: clk_drive_low=1, dat_drive_low=0. When cnt reaches INHIBIT_CYC-1, go to RTS.
- RTS, one cycle: dat_drive_low=1 (start bit 0), clk_drive_low=0. Go to DATA; bitcnt=0; timeout counter=0.
- DATA, on each fall:
  - bitcnt 0..7: dat_drive_low = ~shreg[0], then shift right (LSB first).
  - bitcnt 8: dat_drive_low = ~parity.
  - bitcnt 9: dat_drive_low=0 (stop bit 1).
  - bitcnt 10: sample sync_dat. 0 = ACK, go to WAIT_IDLE. 1 = no ACK, go to ERR.
  - bitcnt increments on every fall.
  - Data changes only in the cycle after a fall is detected, i.e. while the clock is low.
- Timeout counter: cleared on each fall, increments otherwise in DATA. Reaching TIMEOUT_CYC goes to ERR.
- WAIT_IDLE: lines released. When sync_clk=1 and sync_dat=1 together, pulse tx_done, go to IDLE (tx_busy=0 the same cycle). Also bounded by the timeout, which goes to ERR.
- ERR, one cycle: both lines released, pulse tx_error, go to IDLE.
- tx_done and tx_error are never both high in the same cycle.
- tx_start asserted in the same cycle as the return to IDLE is ignored. It is accepted from the next cycle onward.
- Latency from an accepted start to clock release: 1 + INHIBIT_CYC + 1 cycles.
- The block does not interpret device responses such as 0xFA; the receiver path handles those.

Decomposition:
- Shared package ps2_pkg:
  - typedef enum logic [2:0] ps2_tx_state_t {IDLE, INHIBIT, RTS, DATA, WAIT_IDLE, ERR}
  - localparams PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_RESP_ACK=8'hFA
  - function odd_parity(logic [7:0])
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for the clock and data lines. Reusable by the receiver.

Test Plan:
Bench settings: CLK_FREQ_HZ=1_000_000, INHIBIT_US=100 (100 cycles), TIMEOUT_US=2000. The device model is open-drain, clocks at 10 kHz, and samples on rising edges.
- tx_data=0xED, tx_start pulse -> clock held low 100 cycles, then data low. Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACK -> tx_done exactly one pulse; tx_busy falls the same cycle.
- tx_data=0x01 -> parity 0 sampled; tx_data=0x00 -> parity 1; both complete with tx_done.
- Device leaves data high on the 11th clock -> tx_error pulse, no tx_done, both drive_low outputs 0.
- Device never clocks after RTS -> tx_error exactly 2000 cycles after RTS; lines released.
- Second tx_start during DATA -> ignored; original byte completes unchanged. rst=0 asserted mid-DATA -> both drive_low outputs 0 immediately, tx_busy=0, no pulses.
- Two back-to-back bytes (0xED, then 0x07 issued on the first cycle after tx_done) -> both transmitted correctly, each with its own inhibit phase.
